sample_pacer: RTL
=================

SAMPLE_PACER -- requirements
Module: sample_pacer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the sample width in bits.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 8, giving the buffer depth; it is a power of two and at least 2.
REQ-003 The module SHALL have parameter DIV_WIDTH, default 16, giving the width of the rate divider.
REQ-004 The module SHALL have parameter PRIME_LEVEL, default 4, giving the FIFO occupancy required before emission starts; it is between 1 and FIFO_DEPTH.
REQ-005 The module SHALL have ports as follows:
- clk  in  1  -- the only clock; all logic on its rising edge.
- rst  in  1  -- synchronous, active-low reset.
- enable  in  1  -- pacer run request.
- rate_div  in  DIV_WIDTH  -- emission period in clk cycles; 0 is treated as 1.
- wr_data  in  WIDTH  -- sample from upstream.
- wr_valid  in  1  -- wr_data is valid.
- wr_ready  out  1  -- buffer can accept a sample.
- out_data  out  WIDTH  -- paced sample, driving the averaging filter's in_data.
- out_valid  out  1  -- one-cycle strobe, driving the filter's in_valid.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  -- current occupancy.
- underrun_cnt  out  8  -- saturating count of missed ticks.

Function
REQ-006 A sample SHALL be pushed when wr_valid and wr_ready are both high on a rising edge.
REQ-007 wr_ready SHALL be high exactly when fifo_count < FIFO_DEPTH, computed from registered state only.
REQ-008 The buffer SHALL be first-in first-out, with wrapping read and write pointers.
REQ-009 On a simultaneous push and pop, fifo_count SHALL be unchanged.
REQ-010 A push into an empty buffer SHALL NOT be poppable in the same cycle.
REQ-011 The FSM SHALL have three states: IDLE, PRIME and RUN.
REQ-012 From any state, a cycle with enable low SHALL move the FSM to IDLE; no pop occurs in IDLE.
REQ-013 IDLE SHALL go to PRIME when enable is high.
REQ-014 PRIME SHALL go to RUN when fifo_count >= PRIME_LEVEL.
- On that transition, the period counter loads P-1, where P = max(rate_div,1).
REQ-015 In RUN, the counter SHALL decrement each cycle.
- When it is 0, a tick occurs and the counter reloads P-1, with rate_div sampled at reload.
REQ-016 On a tick with fifo_count > 0, the head SHALL be popped.
- out_data is registered with it, and out_valid is high for exactly the next cycle.
REQ-017 On a tick with fifo_count == 0, out_valid SHALL stay low.
- underrun_cnt increments, saturating at 255.
- The FSM returns to PRIME.
REQ-018 Timing: entering RUN at cycle k SHALL give the first out_valid at cycle k+P, then every P cycles while data remains.
REQ-019 out_data SHALL hold its last popped value whenever out_valid is low.
REQ-020 Buffer contents SHALL be preserved across enable deassertion.
REQ-021 Writes SHALL be accepted in every FSM state.
REQ-022 A change to rate_div mid-period SHALL take effect at the next reload only.

Reset
REQ-023 While rst is low on a rising edge, the module SHALL apply the reset state:
- FSM to IDLE;
- pointers, fifo_count, counter and underrun_cnt to 0;
- out_data to 0 and out_valid to 0.
REQ-024 During reset, wr_ready SHALL be 1 and pushes SHALL be ignored.
REQ-025 A reset mid-operation SHALL discard all buffered samples.
- No out_valid is asserted in the cycle after reset releases.

Verification
REQ-026 Priming: rate_div=3, enable=1, push 10,20,30,40 on back-to-back cycles -> RUN entered when count hits 4; out_valid pulses at k+3, k+6, k+9, k+12 with data 10,20,30,40.
REQ-027 Full/backpressure: enable=0, push 9 samples with FIFO_DEPTH=8 -> wr_ready low after the 8th; the 9th is not accepted; fifo_count=8.
REQ-028 Underrun: prime 4 samples, rate_div=1, no further writes -> 4 consecutive out_valid cycles; then underrun_cnt=1 and state=PRIME; out_data holds the 4th sample.
REQ-029 rate_div=0 behaves identically to rate_div=1 -> one sample per cycle.
REQ-030 Reset mid-run: assert rst low for 1 cycle with 5 samples buffered -> fifo_count=0, out_valid=0, underrun_cnt=0, state IDLE.
REQ-031 End-to-end: drive the averaging filter (WIDTH 8, DEPTH 5) from out_data/out_valid with constant samples 100 -> filter output is 100 on every strobe.

Source files
------------

// File: rtl/sample_pacer.sv
// Rate-paced FIFO: buffers upstream samples and emits one every rate_div cycles
// once the buffer has primed, counting ticks that find it empty.
module sample_pacer #(
  parameter int WIDTH       = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [DIV_WIDTH-1:0]            rate_div,
  input  logic [WIDTH-1:0]                wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic [7:0]                      underrun_cnt,
  output logic [1:0]                      fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PRIME_C = CW'(PRIME_LEVEL);

  // Handshake: a sample transfers on a rising edge where wr_valid && wr_ready;
  // wr_ready depends only on registered occupancy, never on wr_valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, period_m1;
  logic [WIDTH-1:0]     out_data_q;
  logic                 out_valid_q;
  logic [7:0]           underrun_q;
  logic                 push, pop, tick;

  // rate_div of 0 behaves as a period of one cycle
  assign period_m1 = (rate_div == '0) ? '0 : rate_div - DIV_WIDTH'(1);

  assign wr_ready = (count_q < DEPTH_C);
  assign push     = wr_valid && wr_ready;
  // occupancy is registered, so a sample pushed this cycle cannot pop this cycle
  assign pop      = tick && (count_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = PRIME;
        PRIME: begin
          if (count_q >= PRIME_C) begin
            state_d = RUN;
            cnt_d   = period_m1;
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = period_m1;
            if (count_q == '0) state_d = PRIME;
          end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= pop;
      if (push) begin
        mem[wr_ptr_q] <= wr_data;
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        out_data_q <= mem[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + AW'(1);
      end
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (tick && count_q == '0 && underrun_q != 8'hFF)
        underrun_q <= underrun_q + 8'd1;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign fifo_count   = count_q;
  assign underrun_cnt = underrun_q;
  assign fsm_state    = state_q;

endmodule
